// File: rtl/nucl_ascii_serializer.sv
// Packed 2-bit nucleotide words -> ASCII byte stream (A/C/G/T) with per-sequence last flag.
// Latency 2 cycles from word accept to first byte; in_ready is registered-full only, outputs hold while stalled.

module nucl_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_push_rdy,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_push_rdy = !w_full;
  assign w_push     = i_push_vld && !w_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module nucl_ascii_serializer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  output logic             in_ready,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic {SH_EMPTY, SH_HOLD} sh_state_t;

  sh_state_t        r_state;
  sh_state_t        w_state_nxt;
  logic [31:0]      r_sh_word;
  logic [3:0]       r_lane;
  logic [LEN_W-1:0] r_site;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             r_out_last;

  logic [31:0]      w_head;
  logic             w_fifo_empty;
  logic             w_out_load;
  logic             w_move;
  logic [1:0]       w_code;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_site_inc;
  logic             w_hit;
  logic             w_done;
  logic             w_pop;

  function automatic logic [7:0] code2ascii(input logic [1:0] c);
    case (c)
      2'b00:   code2ascii = 8'h41;
      2'b01:   code2ascii = 8'h43;
      2'b10:   code2ascii = 8'h47;
      default: code2ascii = 8'h54;
    endcase
  endfunction

  nucl_word_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_vld (in_valid),
    .i_push_dat (in_word),
    .o_push_rdy (in_ready),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_fifo_empty)
  );

  assign w_out_load = !r_out_valid || out_ready;
  assign w_move     = w_out_load && (r_state == SH_HOLD);
  assign w_code     = r_sh_word[{r_lane, 1'b0} +: 2];
  // The length is latched on the first nucleotide so mid-sequence edits wait for the next sequence.
  assign w_len      = (r_site == '0) ? cfg_len : r_len;
  assign w_site_inc = r_site + LEN_W'(1);
  assign w_hit      = (w_len != '0) && (w_site_inc == w_len);
  assign w_done     = w_move && ((r_lane == 4'd15) || w_hit);
  assign w_pop      = ((r_state == SH_EMPTY) || w_done) && !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) r_state <= SH_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop)       w_state_nxt = SH_HOLD;
    else if (w_done) w_state_nxt = SH_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_word   <= '0;
      r_lane      <= '0;
      r_site      <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_sh_word <= w_head;
        r_lane    <= '0;
      end else if (w_move) begin
        r_lane <= r_lane + 4'd1;
      end

      if (w_out_load) begin
        r_out_valid <= w_move;
        r_out_last  <= w_move && w_hit;
        if (w_move) r_out_byte <= code2ascii(w_code);
      end

      if (w_move) begin
        r_site <= w_hit ? '0 : w_site_inc;
        if (r_site == '0) r_len <= cfg_len;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign busy      = !w_fifo_empty || (r_state == SH_HOLD) || r_out_valid;
endmodule

// File: tb/tb_nucl_ascii_serializer.sv
// Directed bench for nucl_ascii_serializer: byte order, length boundaries, backpressure, full FIFO, reset.
module tb_nucl_ascii_serializer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [31:0]      in_word = '0;
  logic             in_ready;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic             busy;

  always #5 clk = ~clk;

  nucl_ascii_serializer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .cfg_len   (cfg_len),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] q_got[$];
  logic [8:0] q_exp[$];
  logic       rdy_mode = 1'b0;
  logic       rdy_val = 1'b1;
  int         phase = 0;
  logic       saw_full = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;
  logic [31:0] bp_words [8] = '{32'hE4E4_E4E4, 32'h1B1B_0000, 32'hFFFF_0000, 32'h0F0F_F0F0,
                                32'h5A5A_A5A5, 32'h3210_CDEF, 32'h9876_5432, 32'hAAAA_5555};

  function automatic logic [7:0] ascii_of(input logic [1:0] c);
    case (c)
      2'b00:   ascii_of = 8'h41;
      2'b01:   ascii_of = 8'h43;
      2'b10:   ascii_of = 8'h47;
      default: ascii_of = 8'h54;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // out_ready driver: either a fixed level or the repeating 1,0,0,1 pattern
  always @(posedge clk) begin
    #2;
    if (rdy_mode) begin
      out_ready = (phase == 0) || (phase == 3);
      phase = (phase + 1) % 4;
    end else begin
      out_ready = rdy_val;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall)
        chk("stall_hold", {23'b0, out_valid, out_last, out_byte}, {23'b0, 1'b1, prev_out});
      if (out_valid && out_ready) q_got.push_back({out_last, out_byte});
      if (!in_ready) saw_full = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_byte};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    int   k;
    logic acc;
    k = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    while (!acc && k < 500) begin
      acc = in_ready;
      cyc(1);
      k++;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic add_word(input logic [31:0] w, input int nl, input logic last_end);
    for (int k = 0; k < nl; k++)
      q_exp.push_back({last_end && (k == nl - 1), ascii_of(w[2*k +: 2])});
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, 32'(q_got.size()), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {23'b0, q_got[i]}, {23'b0, q_exp[i]});
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k;
    k = 0;
    while (q_got.size() < n && k < 3000) begin
      cyc(1);
      k++;
    end
    cyc(20);
    compare_q(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    q_got.delete();
    q_exp.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cyc(3);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_byte",  {24'b0, out_byte},  32'h00);
    chk("rst_out_last",  {31'b0, out_last},  32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    reset = 1'b0;
    cyc(1);

    // map and order, with the two-cycle latency
    cfg_len = '0;
    push(32'h1B1B_1B1B);
    chk("lat_n",   {31'b0, out_valid}, 32'd0);
    cyc(1);
    chk("lat_n1",  {31'b0, out_valid}, 32'd0);
    cyc(1);
    chk("lat_n2",  {31'b0, out_valid}, 32'd1);
    chk("lat_byte", {24'b0, out_byte}, 32'h54);
    add_word(32'h1B1B_1B1B, 16, 1'b0);
    wait_bytes(16, "map");
    chk("map_idle_busy", {31'b0, busy}, 32'd0);

    // length boundary inside the second word
    do_reset();
    cfg_len = 16'd20;
    push(32'h0000_0000);
    push(32'h5555_5555);
    push(32'hFFFF_FFFF);
    add_word(32'h0000_0000, 16, 1'b0);
    add_word(32'h5555_5555, 4, 1'b1);
    add_word(32'hFFFF_FFFF, 16, 1'b0);
    wait_bytes(36, "len20");

    // backpressure with out_ready 1,0,0,1
    cfg_len = '0;
    do_reset();
    saw_full = 1'b0;
    rdy_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(bp_words[i]);
      add_word(bp_words[i], 16, 1'b0);
    end
    wait_bytes(128, "bp");
    chk("bp_saw_full", {31'b0, saw_full}, 32'd1);
    rdy_mode = 1'b0;

    // full FIFO, then push and pop together
    rdy_val = 1'b0;
    do_reset();
    push(32'h1B1B_1B1B);
    push(32'hE4E4_E4E4);
    push(32'h0000_0000);
    push(32'hFFFF_FFFF);
    push(32'h5555_5555);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_busy",     {31'b0, busy},     32'd1);
    in_valid = 1'b1;
    in_word  = 32'hAAAA_AAAA;
    cyc(3);
    chk("full_hold_rdy",   {31'b0, in_ready},  32'd0);
    chk("full_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("full_hold_byte",  {24'b0, out_byte},  32'h54);
    rdy_val = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      cyc(1);
      k++;
    end
    chk("full_rdy_delay", 32'(k), 32'd15);
    cyc(1);
    in_valid = 1'b0;
    add_word(32'h1B1B_1B1B, 16, 1'b0);
    add_word(32'hE4E4_E4E4, 16, 1'b0);
    add_word(32'h0000_0000, 16, 1'b0);
    add_word(32'hFFFF_FFFF, 16, 1'b0);
    add_word(32'h5555_5555, 16, 1'b0);
    add_word(32'hAAAA_AAAA, 16, 1'b0);
    wait_bytes(96, "full");

    // reset after 5 bytes of a 3-word burst
    do_reset();
    push(32'h1B1B_1B1B);
    push(32'hE4E4_E4E4);
    push(32'h0000_0000);
    k = 0;
    while (q_got.size() < 5 && k < 200) begin
      cyc(1);
      k++;
    end
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_valid",    {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy",     {31'b0, busy},      32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready},  32'd1);
    chk("mid_rst_byte",     {24'b0, out_byte},  32'h00);
    reset = 1'b0;
    add_word(32'h1B1B_1B1B, 5, 1'b0);
    compare_q("pre_rst");
    q_got.delete();
    q_exp.delete();
    cfg_len = 16'd3;
    push(32'hE4E4_E4E4);
    add_word(32'hE4E4_E4E4, 3, 1'b1);
    wait_bytes(3, "post_rst");

    // cfg_len edit mid-sequence applies to the next sequence
    do_reset();
    cfg_len = 16'd4;
    push(32'h1B1B_1B1B);
    push(32'hE4E4_E4E4);
    k = 0;
    while (q_got.size() < 2 && k < 200) begin
      cyc(1);
      k++;
    end
    cfg_len = 16'd8;
    add_word(32'h1B1B_1B1B, 4, 1'b1);
    add_word(32'hE4E4_E4E4, 8, 1'b1);
    wait_bytes(12, "lenchg");
    chk("end_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
